// File: rtl/btn_debounce_pkg.sv
// Shared types and constants for the push-button debouncer (package btn_pkg).
package btn_pkg;

  localparam int CNT_W = 24;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // Raw pin level that means "not pressed" for a given polarity.
  function automatic logic released_level(input int active_low);
    return (active_low != 0);
  endfunction

endpackage

// File: rtl/btn_debounce_sync2.sv
// Two-flop synchronizer (module sync2); RST_VAL is the level both flops take in reset.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic d_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_p0 <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      d_p0 <= d;
      q    <= d_p0;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer with registered one-cycle press pulse and debounced level.
// Optional auto-repeat while held: define BTN_DEBOUNCE_REPEAT_EN.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_TIME = 240000,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_DELAY  = 6000000,
  parameter int REPEAT_RATE   = 1200000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic trigx,
  output logic level
);

  localparam int               CNT_MAX = (1 << CNT_W) - 1;
  localparam logic             PIN_REL = released_level(ACTIVE_LOW);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_TIME - 1);

  if (DEBOUNCE_TIME < 1 || DEBOUNCE_TIME > CNT_MAX) begin : g_bad_debounce
    $error("btn_debounce: DEBOUNCE_TIME out of range");
  end
  if (REPEAT_DELAY < 1 || REPEAT_DELAY > CNT_MAX) begin : g_bad_delay
    $error("btn_debounce: REPEAT_DELAY out of range");
  end
  if (REPEAT_RATE < 2 || REPEAT_RATE > CNT_MAX) begin : g_bad_rate
    $error("btn_debounce: REPEAT_RATE out of range");
  end

  logic             btn_p1;
  logic             s;
  btn_state_t       state;
  btn_state_t       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             cnt_done;
  logic             trig_nx;
  logic             level_nx;
  logic             rpt_fire;

  sync2 #(
    .RST_VAL(PIN_REL)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn),
    .q  (btn_p1)
  );

  // s is 1 while the synchronized pin reads "pressed".
  assign s        = btn_p1 ^ PIN_REL;
  assign cnt_done = (cnt == DB_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      trigx <= 1'b0;
      level <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      trigx <= trig_nx;
      level <= level_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (s) begin
          state_nx = PRESS_WAIT;
          cnt_nx   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt_done) begin
          state_nx = HELD;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_nx = RELEASE_WAIT;
          cnt_nx   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_nx = HELD;
        end else if (cnt_done) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Pulse only on a completed press debounce; a bounce back from RELEASE_WAIT is silent.
  always_comb begin
    trig_nx  = ((state == PRESS_WAIT) && s && cnt_done) || rpt_fire;
    level_nx = (state_nx == HELD) || (state_nx == RELEASE_WAIT);
  end

`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic [CNT_W-1:0] rpt_cnt;
  logic             rpt_phase;
  logic             rpt_hit;

  // rpt_phase=0 times the initial delay, 1 times the periodic rate.
  always_comb begin
    rpt_hit  = rpt_phase ? (rpt_cnt == RATE_LAST) : (rpt_cnt == DELAY_LAST);
    rpt_fire = (state == HELD) && s && rpt_hit && !trigx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else if (state != HELD || state_nx != HELD) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b1;
    end else if (!rpt_hit) begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

endmodule
